// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud/oversample helpers.
// Intended for reuse by the companion transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned DEF_CLK_FREQ = 40_000_000;
    localparam int unsigned DEF_BAUD     = 9600;
    localparam int unsigned DEF_OSR      = 16;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned osr);
        return clk_freq / (baud * osr);
    endfunction

    function automatic int unsigned osr_mid_start(input int unsigned osr);
        return osr / 2 - 1;
    endfunction

    function automatic int unsigned osr_mid_bit(input int unsigned osr);
        return osr - 1;
    endfunction

    localparam int unsigned DEF_DIV       = calc_div(DEF_CLK_FREQ, DEF_BAUD, DEF_OSR);
    localparam int unsigned DEF_MID_START = osr_mid_start(DEF_OSR);
    localparam int unsigned DEF_MID_BIT   = osr_mid_bit(DEF_OSR);

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous circular-buffer FIFO; pushes while full are ignored, pops while empty are ignored.
// Head entry is presented combinationally and reads as zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x-style oversampling feeding a small byte FIFO.
// Framing and overrun errors are sticky until err_clr.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OSR        = DEF_OSR,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ser_rx,
    output logic [7:0]                     rd_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    input  logic                           err_clr,
    output logic                           frame_err,
    output logic                           overrun,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           rx_busy
);

    localparam int unsigned DIV       = calc_div(CLK_FREQ, BAUD, OSR);
    localparam int unsigned TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OW        = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int unsigned MID_START = osr_mid_start(OSR);
    localparam int unsigned MID_BIT   = osr_mid_bit(OSR);

    logic [1:0]    r_sync;
    logic          w_rx_s;
    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic [OW-1:0] r_os_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_brk_wait;

    logic          w_tick;
    logic          w_start_det;
    logic          w_mid_start;
    logic          w_mid_bit;
    logic          w_push;
    logic          w_frame_set;
    logic          w_ovr_set;
    logic          w_full;
    logic          w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[0], ser_rx};
    end
    assign w_rx_s = r_sync[1];

    assign w_tick      = (r_tick_cnt == TW'(DIV - 1));
    assign w_mid_start = w_tick && (r_os_cnt == OW'(MID_START));
    assign w_mid_bit   = w_tick && (r_os_cnt == OW'(MID_BIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (!r_brk_wait && !w_rx_s) w_state_nxt = START;
            START:   if (w_mid_start) w_state_nxt = w_rx_s ? IDLE : DATA;
            DATA:    if (w_mid_bit && (r_bit_idx == 3'd7)) w_state_nxt = STOP;
            STOP:    if (w_mid_bit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_start_det = (r_state == IDLE) && !r_brk_wait && !w_rx_s;
        w_push      = (r_state == STOP) && w_mid_bit && w_rx_s;
        w_frame_set = (r_state == STOP) && w_mid_bit && !w_rx_s;
        rx_busy     = (r_state != IDLE);
    end

    // Tick phase restarts on start detection so mid-bit samples line up with the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_start_det || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_cnt   <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_brk_wait <= 1'b0;
        end else begin
            if (w_start_det) begin
                r_os_cnt  <= '0;
                r_bit_idx <= '0;
            end else if (rx_busy && w_tick) begin
                if ((r_state == START) && w_mid_start) r_os_cnt <= '0;
                else if (w_mid_bit)                    r_os_cnt <= '0;
                else                                   r_os_cnt <= r_os_cnt + OW'(1);
            end
            if ((r_state == DATA) && w_mid_bit) begin
                r_shift   <= {w_rx_s, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            // After a low stop bit, hold off start detection until the line has gone high.
            if (w_frame_set)                           r_brk_wait <= 1'b1;
            else if ((r_state == IDLE) && w_rx_s)      r_brk_wait <= 1'b0;
        end
    end

    assign w_ovr_set = w_push && w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_frame_set)  frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (w_ovr_set)    overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_din   (r_shift),
        .i_pop   (rd_ready),
        .o_dout  (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign rd_valid = !w_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo; clock scaled so one bit is DIV*OSR = 64 cycles.
module tb_uart_rx_fifo;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int unsigned T_CLK_FREQ = 614400;
    localparam int unsigned T_BAUD     = 9600;
    localparam int unsigned T_OSR      = 16;
    localparam int unsigned T_DEPTH    = 4;
    localparam int unsigned BIT_CYC    = (T_CLK_FREQ / (T_BAUD * T_OSR)) * T_OSR;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_rx;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       err_clr;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_level;
    logic       rx_busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  sb [$];
    logic        watch_lvl = 1'b0;
    int unsigned max_lvl = 0;

    uart_rx_fifo #(
        .CLK_FREQ   (T_CLK_FREQ),
        .BAUD       (T_BAUD),
        .OSR        (T_OSR),
        .FIFO_DEPTH (T_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_rx     (ser_rx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .err_clr    (err_clr),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line_bit(input logic v);
        ser_rx = v;
        cyc(BIT_CYC);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_v);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(stop_v);
        ser_rx = 1'b1;
    endtask

    task automatic drain();
        int unsigned t = 0;
        rd_ready = 1'b1;
        while (sb.size() != 0 && t < 50) begin
            cyc(1);
            t++;
        end
        cyc(1);
        rd_ready = 1'b0;
        chk("drain_left", sb.size(), 0);
        chk("drain_valid", rd_valid, 0);
    endtask

    // Every handshake the DUT will accept at the next edge is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (sb.size() == 0) chk("sb_underflow", rd_valid, 0);
            else                chk("sb_data", rd_data, sb.pop_front());
        end
        if (watch_lvl && (fifo_level > max_lvl)) max_lvl = fifo_level;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", n_vec);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ser_rx = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
        #1;
        cyc(3);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        cyc(10);

        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        chk("a5_valid", rd_valid, 1);
        chk("a5_data", rd_data, sb[0]);
        chk("a5_level", fifo_level, 1);
        chk("a5_ferr", frame_err, 0);
        chk("a5_ovr", overrun, 0);
        drain();

        ser_rx = 1'b0;
        cyc(8);
        chk("glitch_busy_hi", rx_busy, 1);
        cyc(4);
        ser_rx = 1'b1;
        cyc(60);
        chk("glitch_busy_lo", rx_busy, 0);
        chk("glitch_level", fifo_level, 0);
        chk("glitch_ferr", frame_err, 0);
        chk("glitch_ovr", overrun, 0);

        send_byte(8'h3C, 1'b0);
        cyc(4);
        chk("ferr_set", frame_err, 1);
        chk("ferr_level", fifo_level, 0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("ferr_clr", frame_err, 0);
        sb.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        chk("ferr_after", frame_err, 0);
        drain();

        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        chk("ovr_level", fifo_level, 4);
        chk("ovr_set", overrun, 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        chk("ovr_clr_level", fifo_level, 4);
        drain();

        rd_ready = 1'b1;
        max_lvl = 0;
        watch_lvl = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sb.push_back(8'(16 * i));
            send_byte(8'(16 * i), 1'b1);
        end
        cyc(4);
        watch_lvl = 1'b0;
        rd_ready = 1'b0;
        chk("stream_maxlvl", max_lvl, 1);
        chk("stream_level", fifo_level, 0);
        chk("stream_ovr", overrun, 0);
        chk("stream_left", sb.size(), 0);

        sb.push_back(8'h77);
        send_byte(8'h77, 1'b1);
        send_byte(8'h3C, 1'b0);
        cyc(4);
        chk("pre_rst_ferr", frame_err, 1);
        chk("pre_rst_level", fifo_level, 1);
        line_bit(1'b0);
        ser_rx = 1'b1;
        cyc(4 * BIT_CYC + BIT_CYC / 2);
        chk("pre_rst_busy", rx_busy, 1);
        rst = 1'b1;
        #2;
        chk("mid_rst_busy", rx_busy, 0);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_ovr", overrun, 0);
        sb.delete();
        cyc(2);
        rst = 1'b0;
        cyc(6 * BIT_CYC);
        chk("post_rst_busy", rx_busy, 0);
        sb.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        chk("post_rst_valid", rd_valid, 1);
        chk("post_rst_data", rd_data, sb[0]);
        drain();
        chk("post_rst_ferr", frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
